// File: rtl/dmem_responder.sv
// dmem_responder: data-memory target with wait states, byte-lane stores and sign/zero-extended loads
module dmem_responder #(
    parameter int DEPTH   = 1024,
    parameter int LATENCY = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_we_i,
    input  logic [2:0]  req_funct3_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [31:0] rsp_rdata_o,
    output logic        rsp_err_o
);
    localparam int IW = $clog2(DEPTH);
    localparam logic [3:0] LAT_M1 = 4'(LATENCY == 0 ? 0 : LATENCY - 1);
    localparam logic [2:0] F3_B = 3'd0, F3_H = 3'd1, F3_W = 3'd2, F3_BU = 3'd4, F3_HU = 3'd5;
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
    state_t      r_state, w_next;
    logic [3:0]  r_cnt;
    logic        r_we, r_err;
    logic [2:0]  r_f3;
    logic [31:0] r_addr, r_wdata, r_rdata;
    logic [31:0] r_mem [DEPTH];
    logic        w_acc, w_commit, w_we, w_err, w_bad_f3, w_mis, w_oor;
    logic [2:0]  w_f3;
    logic [31:0] w_addr, w_wdata, w_word, w_ld, w_wd;
    logic [IW-1:0] w_idx;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [3:0]  w_be;
    assign req_ready_o = !rst && r_state == IDLE;
    assign rsp_valid_o = !rst && r_state == RESP;
    assign rsp_rdata_o = rst ? '0 : r_rdata;
    assign rsp_err_o   = !rst && r_err;
    assign w_acc = req_valid_i && req_ready_o;
    // With zero latency the commit edge is the accept edge, so the live request is used
    assign w_commit = !rst && ((w_acc && LATENCY == 0) || (r_state == WAIT && r_cnt == 4'd0));
    assign w_we    = r_state == IDLE ? req_we_i : r_we;
    assign w_f3    = r_state == IDLE ? req_funct3_i : r_f3;
    assign w_addr  = r_state == IDLE ? req_addr_i : r_addr;
    assign w_wdata = r_state == IDLE ? req_wdata_i : r_wdata;
    assign w_idx   = w_addr[IW+1:2];
    assign w_word  = r_mem[w_idx];
    assign w_byte  = w_word[{w_addr[1:0], 3'b000} +: 8];
    assign w_half  = w_addr[1] ? w_word[31:16] : w_word[15:0];
    assign w_ld = w_f3 == F3_B  ? {{24{w_byte[7]}}, w_byte} :
                  w_f3 == F3_BU ? {24'd0, w_byte} :
                  w_f3 == F3_H  ? {{16{w_half[15]}}, w_half} :
                  w_f3 == F3_HU ? {16'd0, w_half} : w_word;
    assign w_bad_f3 = w_we ? w_f3 > F3_W : !(w_f3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
    assign w_mis = (w_f3[1:0] == 2'd1 && w_addr[0]) || (w_f3[1:0] == 2'd2 && w_addr[1:0] != 2'd0);
    assign w_oor = w_addr >= 32'(DEPTH * 4);
    assign w_err = w_bad_f3 || w_mis || w_oor;
    assign w_be = w_f3[1:0] == 2'd0 ? 4'b0001 << w_addr[1:0] :
                  w_f3[1:0] == 2'd1 ? (w_addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    assign w_wd = w_f3[1:0] == 2'd0 ? {4{w_wdata[7:0]}} :
                  w_f3[1:0] == 2'd1 ? {2{w_wdata[15:0]}} : w_wdata;
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: if (w_acc) begin
                if (LATENCY == 0) w_next = RESP;
                else w_next = WAIT;
            end
            WAIT: if (r_cnt == 4'd0) w_next = RESP;
            RESP: if (rsp_ready_i) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= 4'd0;
            r_rdata <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_next;
            r_cnt   <= w_acc ? LAT_M1 : (r_state == WAIT && r_cnt != 4'd0) ? r_cnt - 4'd1 : r_cnt;
            if (w_acc) begin
                r_we    <= req_we_i;
                r_f3    <= req_funct3_i;
                r_addr  <= req_addr_i;
                r_wdata <= req_wdata_i;
            end
            if (w_commit) begin
                r_rdata <= (w_we || w_err) ? '0 : w_ld;
                r_err   <= w_err;
            end
        end
    end
    always_ff @(posedge clk)
        if (w_commit && w_we && !w_err)
            for (int b = 0; b < 4; b++)
                if (w_be[b]) r_mem[w_idx][8*b +: 8] <= w_wd[8*b +: 8];
endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory target for the core's load/store port; the responding end of the core's memory request interface.
- Accepts one request at a time over a valid/ready handshake and inserts a configurable number of wait states.
- Performs the byte/half/word store with byte lanes selected by funct3 and address.
- Returns load data sign- or zero-extended per the core_pkg FUNCT3_LOAD_* codes, and flags misaligned, out-of-range or illegal-funct3 accesses.

Parameters:
- DEPTH, DATA_MEM_DEPTH (1024): number of 32-bit words; byte address space is DEPTH*4.
- LATENCY, 1: wait-state cycles between request accept and response; legal range 0..15.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  synchronous active-high reset.
- req_valid_i  in  1  request present.
- req_ready_o  out  1  responder can accept a request.
- req_we_i  in  1  1 = store, 0 = load.
- req_funct3_i  in  3  core_pkg FUNCT3_LOAD_* / FUNCT3_STORE_* code.
- req_addr_i  in  DATA_WIDTH  byte address.
- req_wdata_i  in  DATA_WIDTH  store data, right-aligned (byte in [7:0], half in [15:0]).
- rsp_valid_o  out  1  response present.
- rsp_ready_i  in  1  core accepts the response.
- rsp_rdata_o  out  DATA_WIDTH  extended load data; 0 for stores and errors.
- rsp_err_o  out  1  access error; qualified by rsp_valid_o.

Behaviour:
- Reset and reset values:
  - Reset is synchronous and active-high; one clock, clk.
  - While rst is high: state = IDLE, req_ready_o = 0, rsp_valid_o = 0, rsp_rdata_o = 0, rsp_err_o = 0, wait counter = 0.
  - Memory array contents are not reset.
- States:
  - IDLE: req_ready_o = 1 (when rst is low). Accept occurs when req_valid_i && req_ready_o. On accept, latch we, funct3, addr and wdata.
  - IDLE transitions: go to WAIT if LATENCY > 0, else to RESP.
  - WAIT: req_ready_o = 0. The counter loads LATENCY-1 on accept and decrements each cycle. At 0, go to RESP.
  - RESP: rsp_valid_o = 1. rsp_rdata_o and rsp_err_o are held stable until rsp_ready_i = 1; then go to IDLE.
- Commit point: the store write and the load read sample both happen on the clock edge entering RESP.
  - Latency from accept edge to first rsp_valid_o cycle = LATENCY+1 cycles.
- No accept is possible in the same cycle as a response handshake. Minimum request spacing is LATENCY+2 cycles.
- Request inputs are ignored outside IDLE, and are not required to be held after accept.
- Error conditions (checked on latched request; any one sets rsp_err_o = 1, rsp_rdata_o = 0 and suppresses the write):
  - Illegal funct3: loads allow only 0, 1, 2, 4, 5; stores allow only 0, 1, 2.
  - Misaligned access: half with addr[0] = 1, or word with addr[1:0] != 0.
  - Out of range: addr >= DEPTH*4.
- Word index = addr[$clog2(DEPTH)+1:2].
- Store lanes:
  - SB writes byte lane addr[1:0] with wdata[7:0].
  - SH writes lanes {addr[1],1} and {addr[1],0} with wdata[15:0].
  - SW writes all 4 lanes.
  - Unwritten lanes are unchanged.
  - Store response: rsp_rdata_o = 0, rsp_err_o = 0.
- Load extract:
  - LB/LBU: byte at lane addr[1:0], sign- or zero-extended to 32 bits.
  - LH/LHU: half at addr[1], sign- or zero-extended.
  - LW: full word.
- A load following a store to the same address returns the new data; the write is committed before the next accept is possible.
- Backpressure: if rsp_ready_i stays low, remain in RESP indefinitely with outputs unchanged.
- Reset mid-operation:
  - In WAIT: the transaction is dropped and the write is not performed.
  - In RESP: the response is dropped, but a store already committed stays in memory.

Test Plan:
- LATENCY=1. SW addr 0x10 data 0xDEADBEEF, then LW 0x10 → rsp_rdata_o = 0xDEADBEEF, err 0; rsp_valid_o first high 2 cycles after each accept edge.
- After the above, SB addr 0x11 data 0x7F; LB 0x11 → 0x0000007F; LB 0x13 → 0xFFFFFFDE; LBU 0x13 → 0x000000DE; LW 0x10 → 0xDEAD7FEF.
- SH addr 0x22 data 0x8001; LH 0x22 → 0xFFFF8001; LHU 0x22 → 0x00008001; LW 0x20 → upper half 0x8001, lower half unchanged.
- Errors, each → err 1, rdata 0, and a follow-up LW shows memory unchanged:
  - LW 0x13 (misaligned).
  - SH 0x21 (misaligned).
  - LW 0x1000 (out of range, DEPTH=1024).
  - load funct3 = 3 (illegal).
  - store funct3 = 4 (illegal).
- Backpressure: hold rsp_ready_i = 0 for 5 cycles in RESP → rsp_valid_o stays 1, data stable, req_ready_o = 0; release → IDLE next cycle and req_ready_o = 1.
- Reset and LATENCY=0:
  - Assert rst during WAIT of an SW 0x40 0x12345678 → all outputs 0 the next cycle; a later LW 0x40 returns the previous contents.
  - With LATENCY=0, responses are valid 1 cycle after accept.
